pwm_capture: RTL



---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_in_sync.sv | 39 +++
 rtl/pwm_capture.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM capture block.
package pwm_pkg;

  localparam int unsigned PWM_PERIOD_66M  = 1_320_000;
  localparam int unsigned DEFAULT_TIMEOUT = 2 * PWM_PERIOD_66M;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus a history flop for edge detection.
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign prev = prev_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles, with a sticky
// dead-line timeout. Results update only on the one-cycle meas_valid strobe.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic sync, prev, rise, fall;

  pwm_in_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (pwm_in),
    .sync (sync),
    .prev (prev),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       prime_q, prime_d;
  logic             at_limit;
  logic             unarmed;

  // prime_q keeps IDLE from trusting sync until the synchronizer holds a real
  // pin sample, so a pulse already high at reset release is never measured.
  always_comb begin
    at_limit     = (cnt_q == TIMEOUT_C);
    unarmed      = (state_q == IDLE) || (state_q == ARMED);
    state_d      = state_q;
    hi_len_d     = hi_len_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    prime_d      = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;

    if (rise || (fall && unarmed)) begin
      cnt_d = ONE_C;
    end else if (at_limit) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end

    if (at_limit) begin
      timeout_d = 1'b1;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if ((prime_q == 2'd2) && !sync) state_d = ARMED;
        end
        ARMED: begin
          if (rise) state_d = HIGH;
        end
        HIGH: begin
          if (fall) begin
            hi_len_d = cnt_q;
            state_d  = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt_d   = hi_len_q;
            period_cnt_d = cnt_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            state_d      = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_len_q     <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      prime_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_len_q     <= hi_len_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      prime_q      <= prime_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign level      = sync;

endmodule
